load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit that sits directly upstream of the 64-entry, 64-bit data memory and is its only client. Accepts byte-addressed load/store requests of 1/2/4/8 bytes over a valid/ready handshake and converts them to doubleword accesses on the memory's write/read/address/data ports. Sub-doubleword stores are done as read-modify-write. Load results are lane-extracted and sign- or zero-extended, and are returned with an error flag over a second valid/ready handshake.

## Interface
- ADDR_W, 48: byte-address width; equals the data memory address width.
- WORD_IDX_W, 6: log2 of memory depth in doublewords.

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_signed  in  1  loads only: sign-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response present; held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range request
- mem_write  out  1  to data memory write enable
- mem_read  out  1  to data memory read enable
- mem_address  out  ADDR_W  doubleword index, equal to byte address >> 3
- mem_wdata  out  64  to data memory write data
- mem_rdata  in  64  from data memory, combinational read

## Operation
- **Endianness and lanes:** little-endian. Lane offset is addr[2:0].
- **Misaligned:** addr[size-1:0] != 0 for size ≥ 1.
- **Out of range:** addr[ADDR_W-1:WORD_IDX_W+3] != 0. The memory would otherwise alias the address, so it is rejected.
- **FSM states:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:**
  - req_ready = 1.
  - On req_valid, latch all request fields.
  - Error request → RESP with resp_err = 1. No memory port activity.
  - Otherwise → ACCESS.
- **ACCESS:**
  - mem_address = latched addr >> 3, and mem_read = 1.
  - Load: extract size bytes at the offset, extend them (sign-extend if req_signed, else zero-extend), register into resp_rdata, then → RESP.
  - Dword store: mem_write = 1 and mem_wdata = wdata, then → RESP.
  - Sub-dword store: register the merge word (mem_rdata with the target lanes replaced by the low bytes of wdata), then → WRITE.
- **WRITE:** mem_address is held, mem_write = 1, mem_wdata = merge word, then → RESP.
- **RESP:**
  - resp_valid = 1.
  - On resp_ready → IDLE. resp_valid, resp_err and resp_rdata clear on the same edge.
- **Memory port idle values:** mem_write and mem_read are 0 outside the cycles above. mem_write is asserted for exactly one cycle per successful store and never for loads or errors.
- **Reset values:** all outputs 0 (req_ready = 0 during reset), state IDLE. Deasserting rst_n mid-RMW abandons the write; no partial write ever reaches memory after the reset edge.

## Timing
- Request accepted at edge T (req_valid && req_ready).
- Response latency, measured as the first cycle resp_valid is high:
  - load and dword store: after edge T+2
  - sub-dword store: after edge T+3
  - error: after edge T+1
- The memory write for a dword store lands at edge T+2; for a sub-dword store at edge T+3.
- A load issued after a store's response completes observes the stored data.
- Throughput is one request in flight. req_ready returns the cycle after resp_ready handshakes, so there is no request/response overlap.
- resp_ready held low stalls the unit in RESP indefinitely; outputs stay stable.

## Structure
- Shared package: size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D) and the FSM state enum.
- One natural sub-module: lane_align. It is combinational and provides:
  - the load extract/extend function of (word, offset, size, signed);
  - the store merge function of (old word, new data, offset, size).
- The same lane_align instance serves both paths.
- The top level holds the FSM, request latches and response registers.

## Test plan
- **Dword round-trip:** store dword 0x0123456789ABCDEF to addr 0x18 → one mem_write cycle, mem_address 3, resp_err 0. Then load dword from 0x18 → resp_rdata 0x0123456789ABCDEF at T+2.
- **Sub-dword RMW:** word 3 = 0x0123456789ABCDEF; store byte 0xFF at addr 0x1A → word 3 = 0x0123456789FFCDEF, resp at T+3. Then load signed byte at 0x1A → 0xFFFFFFFFFFFFFFFF; unsigned → 0x00000000000000FF.
- **Signed half and word loads:** word 0 = 0x80007FFF_12348001. Signed half at addr 0 → 0xFFFFFFFFFFFF8001. Unsigned word at addr 4 → 0x0000000080007FFF.
- **Errors:** half at addr 0x1 and dword at addr 0x204 → resp_err 1 at T+1, resp_rdata 0, and no mem_write/mem_read pulse.
- **Backpressure:** hold resp_ready 0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready 0. Release → req_ready high the next cycle.
- **Reset mid-RMW:** assert rst_n = 0 in the ACCESS cycle of a byte store → the next cycle has no mem_write, memory is unchanged and all outputs are 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size encoding,
// FSM state encoding and the alignment helper.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
        logic res;
        case (sz)
            SZ_B:    res = 1'b0;
            SZ_H:    res = off[0];
            SZ_W:    res = |off[1:0];
            SZ_D:    res = |off;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: load extract/extend and store merge for a
// little-endian 64-bit doubleword.
module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [63:0] word,
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);

    // Pull the addressed lanes down to bit 0 and extend them to 64 bits.
    function automatic logic [63:0] extract(input logic [63:0] w, input logic [2:0] off,
                                            input logic [1:0] sz, input logic sg);
        logic [63:0] sh;
        logic [63:0] res;
        sh = w >> {off, 3'b000};
        case (sz)
            SZ_B:    res = sg ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
            SZ_H:    res = sg ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            SZ_W:    res = sg ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            SZ_D:    res = sh;
            default: res = sh;
        endcase
        return res;
    endfunction

    // Replace the addressed lanes of the old word with the low bytes of the new data.
    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] d,
                                          input logic [2:0] off, input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            SZ_D:    m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return (old_w & ~(m << {off, 3'b000})) | ((d & m) << {off, 3'b000});
    endfunction

    // Both paths are evaluated continuously; the FSM picks which result to use.
    always_comb begin
        load_data  = extract(word, offset, size, sign_ext);
        merge_data = merge(word, data, offset, size);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests in, doubleword
// accesses to the data memory out, sub-doubleword stores via read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W     = 48,
    parameter int WORD_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    lsu_state_e        state_r, state_next_s;
    logic              ready_r;
    logic              write_r, signed_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [63:0]       wdata_r, merge_r;
    logic              resp_valid_r, resp_err_r;
    logic [63:0]       resp_rdata_r;
    logic              accept_s, err_s;
    logic [63:0]       load_s, merge_s;

    // Aliasing addresses beyond the memory are rejected along with misaligned ones.
    assign accept_s = req_valid && ready_r;
    assign err_s    = (|req_addr[ADDR_W-1:WORD_IDX_W+3]) || misaligned(req_addr[2:0], req_size);

    load_store_unit_lane_align u_lane_align (
        .word       (mem_rdata),
        .data       (wdata_r),
        .offset     (addr_r[2:0]),
        .size       (size_r),
        .sign_ext   (signed_r),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = err_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (write_r && (size_r != SZ_D)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_WRITE: state_next_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM memory-port outputs; enables are gated by reset so nothing reaches memory during it.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = 64'd0;
        case (state_r)
            ST_ACCESS: begin
                mem_read    = rst_n;
                mem_address = {3'b000, addr_r[ADDR_W-1:3]};
                if (write_r && (size_r == SZ_D)) begin
                    mem_write = rst_n;
                    mem_wdata = wdata_r;
                end else begin
                    mem_wdata = 64'd0;
                end
            end
            ST_WRITE: begin
                mem_write   = rst_n;
                mem_address = {3'b000, addr_r[ADDR_W-1:3]};
                mem_wdata   = merge_r;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    // Request latches, merge word and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_r      <= 1'b0;
            write_r      <= 1'b0;
            signed_r     <= 1'b0;
            size_r       <= 2'd0;
            addr_r       <= '0;
            wdata_r      <= 64'd0;
            merge_r      <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'd0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r  <= req_write;
                        signed_r <= req_signed;
                        size_r   <= req_size;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        if (err_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 64'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_r) begin
                        resp_rdata_r <= load_s;
                        resp_valid_r <= 1'b1;
                    end else if (size_r == SZ_D) begin
                        resp_valid_r <= 1'b1;
                    end else begin
                        merge_r <= merge_s;
                    end
                end
                ST_WRITE: resp_valid_r <= 1'b1;
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64 x 64-bit memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [47:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_write, mem_read;
    logic [47:0] mem_address;
    logic [63:0] mem_wdata, mem_rdata;

    logic [63:0] mem [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [47:0] last_wa = 48'd0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_address[5:0]];

    // Memory model and port activity monitor.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[5:0]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_address;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request/response; hold = cycles resp_ready stays low after resp_valid.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [47:0] a, input logic [63:0] d, input int hold,
                           output int lat, output logic [63:0] rd, output logic er);
        int   n;
        logic stable;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd || req_ready) stable = 1'b0;
        end
        if (hold > 0) chk("bp_stable", 64'(stable), 64'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_resp", 64'(req_ready), 64'd1);
        chk("valid_cleared", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] rd;
        logic        er;
        int          w0, r0;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 48'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_en", {62'd0, mem_write, mem_read}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        rst_n = 1'b1;

        // Dword round trip
        w0 = wr_cnt;
        run_req(1'b1, 2'd3, 1'b0, 48'h18, 64'h0123456789ABCDEF, 0, lat, rd, er);
        chk("st_d_lat", 64'(lat), 64'd2);
        chk("st_d_err", 64'(er), 64'd0);
        chk("st_d_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        chk("st_d_addr", 64'(last_wa), 64'd3);
        chk("st_d_mem", mem[3], 64'h0123456789ABCDEF);
        w0 = wr_cnt;
        run_req(1'b0, 2'd3, 1'b0, 48'h18, 64'd0, 0, lat, rd, er);
        chk("ld_d_lat", 64'(lat), 64'd2);
        chk("ld_d_data", rd, 64'h0123456789ABCDEF);
        chk("ld_d_no_wr", 64'(wr_cnt - w0), 64'd0);

        // Sub-dword RMW
        w0 = wr_cnt;
        run_req(1'b1, 2'd0, 1'b0, 48'h1A, 64'h123456789ABCDEFF, 0, lat, rd, er);
        chk("st_b_lat", 64'(lat), 64'd3);
        chk("st_b_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        chk("st_b_mem", mem[3], 64'h0123456789FFCDEF);
        chk("st_b_rdata", rd, 64'd0);
        run_req(1'b0, 2'd0, 1'b1, 48'h1A, 64'd0, 0, lat, rd, er);
        chk("ld_bs", rd, 64'hFFFFFFFFFFFFFFFF);
        run_req(1'b0, 2'd0, 1'b0, 48'h1A, 64'd0, 0, lat, rd, er);
        chk("ld_bu", rd, 64'h00000000000000FF);
        run_req(1'b1, 2'd1, 1'b0, 48'h1C, 64'h000000000000BEEF, 0, lat, rd, er);
        chk("st_h_mem", mem[3], 64'h0123BEEF89FFCDEF);

        // Signed half and word loads
        run_req(1'b1, 2'd3, 1'b0, 48'h0, 64'h80007FFF12348001, 0, lat, rd, er);
        run_req(1'b0, 2'd1, 1'b1, 48'h0, 64'd0, 0, lat, rd, er);
        chk("ld_hs", rd, 64'hFFFFFFFFFFFF8001);
        run_req(1'b0, 2'd2, 1'b0, 48'h4, 64'd0, 0, lat, rd, er);
        chk("ld_wu", rd, 64'h0000000080007FFF);
        run_req(1'b0, 2'd2, 1'b1, 48'h4, 64'd0, 0, lat, rd, er);
        chk("ld_ws", rd, 64'hFFFFFFFF80007FFF);
        run_req(1'b0, 2'd1, 1'b0, 48'h6, 64'd0, 0, lat, rd, er);
        chk("ld_hu6", rd, 64'h0000000000008000);

        // Errors: misaligned, out of range, and both
        w0 = wr_cnt; r0 = rd_cnt;
        run_req(1'b0, 2'd1, 1'b0, 48'h1, 64'd0, 0, lat, rd, er);
        chk("err_mis_lat", 64'(lat), 64'd1);
        chk("err_mis_flag", 64'(er), 64'd1);
        chk("err_mis_rdata", rd, 64'd0);
        run_req(1'b1, 2'd3, 1'b0, 48'h204, 64'hDEADBEEFDEADBEEF, 0, lat, rd, er);
        chk("err_oor_lat", 64'(lat), 64'd1);
        chk("err_oor_flag", 64'(er), 64'd1);
        run_req(1'b1, 2'd3, 1'b0, 48'h200, 64'hDEADBEEFDEADBEEF, 0, lat, rd, er);
        chk("err_oor2_flag", 64'(er), 64'd1);
        chk("err_no_wr", 64'(wr_cnt - w0), 64'd0);
        chk("err_no_rd", 64'(rd_cnt - r0), 64'd0);
        chk("err_mem0", mem[0], 64'h80007FFF12348001);
        run_req(1'b0, 2'd3, 1'b0, 48'h1F8, 64'd0, 0, lat, rd, er);
        chk("last_word_ok", 64'(er), 64'd0);

        // Backpressure
        run_req(1'b0, 2'd3, 1'b0, 48'h18, 64'd0, 5, lat, rd, er);
        chk("bp_data", rd, 64'h0123BEEF89FFCDEF);

        // Reset in the ACCESS cycle of a byte store
        @(negedge clk);
        w0 = wr_cnt;
        chk("rmw_rst_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 48'h1A; req_wdata = 64'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmw_rst_wr", 64'(mem_write), 64'd0);
        chk("rmw_rst_outs", {59'd0, mem_read, req_ready, resp_valid, resp_err, 1'b0}, 64'd0);
        chk("rmw_rst_bus", mem_wdata | 64'(mem_address) | resp_rdata, 64'd0);
        @(negedge clk);
        chk("rmw_rst_wr_cnt", 64'(wr_cnt - w0), 64'd0);
        chk("rmw_rst_mem", mem[3], 64'h0123BEEF89FFCDEF);
        rst_n = 1'b1;
        run_req(1'b0, 2'd3, 1'b0, 48'h18, 64'd0, 0, lat, rd, er);
        chk("post_rst_ld", rd, 64'h0123BEEF89FFCDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
